// File: rtl/points_encoder_if.sv
// Handshake bundle between the points BCD encoder and its producer/consumer.
// The producer side drives bcd_in/in_valid and takes the result with out_ready.
interface points_encoder_if #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);
   logic [4*DIGITS-1:0] bcd_in;
   logic                in_valid;
   logic                in_ready;
   logic [BIN_W-1:0]    points;
   logic                err;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output bcd_in,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  points,
      input  err,
      input  out_valid
   );

   modport slave (
      input  bcd_in,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output points,
      output err,
      output out_valid
   );
endinterface

// File: rtl/points_encoder.sv
// Packed BCD score to binary points, one bit per clock, using
// reverse double-dabble (shift right, then subtract 3 from digits >= 8).
module points_encoder #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic clk,
   input  logic rst_n,
   points_encoder_if.slave bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   generate
      if ((10 ** DIGITS) - 1 >= (2 ** BIN_W)) begin : g_bad_width
         $error("BIN_W too narrow for DIGITS");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [BCD_W-1:0] bcd_reg;
   logic [BIN_W-1:0] bin_reg;
   logic [CNT_W-1:0] cnt;
   logic [BIN_W-1:0] points_q;
   logic             err_q;
   logic             out_valid_q;
   logic             in_ready_q;

   logic             bad_digit;
   logic [BCD_W-1:0] sh_bcd;
   logic [BCD_W-1:0] adj_bcd;
   logic [BIN_W-1:0] sh_bin;
   logic             last_step;

   always_comb begin
      bad_digit = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bus.bcd_in[4*d +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end

   // Corrections look at the post-shift digits; mod-16 wrap is safe since d >= 8.
   always_comb begin
      {sh_bcd, sh_bin} = {bcd_reg, bin_reg} >> 1;
      adj_bcd = sh_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (sh_bcd[4*d+3]) begin
            adj_bcd[4*d +: 4] = sh_bcd[4*d +: 4] - 4'd3;
         end
      end
   end

   assign last_step = (cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bcd_reg     <= '0;
         bin_reg     <= '0;
         cnt         <= '0;
         points_q    <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  if (bad_digit) begin
                     points_q    <= '0;
                     err_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end else begin
                     bcd_reg <= bus.bcd_in;
                     bin_reg <= '0;
                     cnt     <= '0;
                     state   <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               bcd_reg <= adj_bcd;
               bin_reg <= sh_bin;
               cnt     <= cnt + 1'b1;
               if (last_step) begin
                  points_q    <= sh_bin;
                  err_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.points    = points_q;
   assign bus.err       = err_q;
   assign bus.out_valid = out_valid_q;

   a_residual_zero : assert property (
      @(posedge clk) disable iff (!rst_n)
      (state == SHIFT && last_step) |-> (adj_bcd == '0)
   );

endmodule

// File: tb/tb_points_encoder.sv
// Directed checks of the points BCD encoder, ending with a full sweep
// of every valid three-digit BCD code against a decimal decode model.
module tb_points_encoder;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   points_encoder_if #(.DIGITS(3), .BIN_W(10)) bus ();

   points_encoder #(.DIGITS(3), .BIN_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int bcd_value(input logic [11:0] b);
      return b[11:8] * 100 + b[7:4] * 10 + b[3:0];
   endfunction

   // Entered and left at 1ns after a rising edge.
   task automatic run_one(
      input  logic [11:0] bcd,
      input  int          stall,
      output bit          acc,
      output int          lat,
      output logic [9:0]  pts,
      output logic        e
   );
      acc = 1'b0;
      lat = -1;
      pts = 'x;
      e   = 1'bx;
      for (int k = 0; k < 50 && !bus.in_ready; k++) begin
         @(posedge clk); #1;
      end
      if (!bus.in_ready) return;
      bus.bcd_in   = bcd;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.bcd_in   = 12'hFFF;
      acc = 1'b1;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) begin
         lat = -1;
         return;
      end
      pts = bus.points;
      e   = bus.err;
      repeat (stall) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n         = 1'b0;
      bus.bcd_in    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.points !== 10'd0 || bus.err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ov=%b pts=%0d err=%b want 0/0/0",
                  bus.out_valid, bus.points, bus.err);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_out_ready: got ov=%b ir=%b want 0/1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_max;
      int lat;
      bus.bcd_in   = 12'h999;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL max_in_ready_drop: got %b want 0", bus.in_ready);
      end
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (lat !== 10) begin
         miscompares++;
         $display("FAIL max_latency: got %0d edges want 10", lat);
      end
      vectors++;
      if (bus.points !== 10'h3E7 || bus.err !== 1'b0) begin
         miscompares++;
         $display("FAIL max_result: got pts=%h err=%b want 3e7/0",
                  bus.points, bus.err);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL max_release: got ov=%b ir=%b want 0/1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_basic;
      logic [11:0] codes [3];
      int          want  [3];
      bit          acc;
      int          lat;
      logic [9:0]  pts;
      logic        e;
      codes = '{12'h000, 12'h512, 12'h001};
      want  = '{0, 512, 1};
      for (int i = 0; i < 3; i++) begin
         run_one(codes[i], 0, acc, lat, pts, e);
         vectors++;
         if (!acc || lat !== 10 || pts !== 10'(want[i]) || e !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_%h: got acc=%b lat=%0d pts=%0d err=%b want 1/10/%0d/0",
                     codes[i], acc, lat, pts, e, want[i]);
         end
      end
   endtask

   task automatic test_bad_digit;
      bit         acc;
      int         lat;
      logic [9:0] pts;
      logic       e;
      run_one(12'h0A5, 0, acc, lat, pts, e);
      vectors++;
      if (!acc || lat !== 0 || pts !== 10'd0 || e !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_digit: got acc=%b lat=%0d pts=%0d err=%b want 1/0/0/1",
                  acc, lat, pts, e);
      end
      run_one(12'h042, 0, acc, lat, pts, e);
      vectors++;
      if (!acc || lat !== 10 || pts !== 10'd42 || e !== 1'b0) begin
         miscompares++;
         $display("FAIL after_bad: got acc=%b lat=%0d pts=%0d err=%b want 1/10/42/0",
                  acc, lat, pts, e);
      end
   endtask

   task automatic test_backpressure;
      int lat;
      bus.bcd_in   = 12'h250;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.bcd_in   = 12'h111;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.points !== 10'd250 ||
             bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_%0d: got ov=%b pts=%0d err=%b ir=%b want 1/250/0/0",
                     c, bus.out_valid, bus.points, bus.err, bus.in_ready);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: got ov=%b ir=%b want 0/1",
                  bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_accept: got ir=%b want 0", bus.in_ready);
      end
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (lat !== 10 || bus.points !== 10'd111) begin
         miscompares++;
         $display("FAIL bp_next: got lat=%0d pts=%0d want 10/111", lat, bus.points);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_mid_reset;
      bit         acc;
      int         lat;
      logic [9:0] pts;
      logic       e;
      bus.bcd_in   = 12'h777;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.points !== 10'd0) begin
         miscompares++;
         $display("FAIL mid_reset: got ov=%b pts=%0d want 0/0",
                  bus.out_valid, bus.points);
      end
      #1 rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: got ir=%b ov=%b want 1/0",
                  bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
      run_one(12'h123, 0, acc, lat, pts, e);
      vectors++;
      if (!acc || lat !== 10 || pts !== 10'd123 || e !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_recover: got acc=%b lat=%0d pts=%0d err=%b want 1/10/123/0",
                  acc, lat, pts, e);
      end
   endtask

   task automatic test_back_to_back;
      logic [11:0] code;
      bit          acc;
      int          lat;
      logic [9:0]  pts;
      logic        e;
      int          want;
      for (int v = 0; v < 1000; v++) begin
         code = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         want = bcd_value(code);
         run_one(code, int'($urandom_range(0, 3)), acc, lat, pts, e);
         vectors++;
         if (!acc || lat !== 10 || pts !== 10'(want) || e !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_%h: got acc=%b lat=%0d pts=%0d err=%b want 1/10/%0d/0",
                     code, acc, lat, pts, e, want);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_max();
      test_basic();
      test_bad_digit();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
